// File: rtl/trace_commit_arbiter_pkg.sv
// Shared types for the commit-trace path: CPU retire-slot bus, trace record and arbiter state.
package trace_commit_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  wstrb;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } debug_bus_t;

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } trace_rec_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } trace_arb_state_e;

  // Bytes whose strobe is clear are reported as zero so traces compare byte-exact.
  function automatic logic [31:0] mask_wdata(input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO with two ordered write ports (port 0 is older) and one read port.
module trace_fifo
  import trace_commit_arbiter_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr0_en,
  input  trace_rec_t    wr0_data,
  input  logic          wr1_en,
  input  trace_rec_t    wr1_data,
  input  logic          rd_en,
  output trace_rec_t    rd_data,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr1_addr;
  logic [CW-1:0] count_q, count_d;
  trace_rec_t    mem_q [DEPTH];

  always_comb begin
    wr1_addr = wr_ptr_q + AW'(wr0_en);
    wr_ptr_d = wr_ptr_q + AW'(wr0_en) + AW'(wr1_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (wr0_en) mem_q[wr_ptr_q] <= wr0_data;
    if (wr1_en) mem_q[wr1_addr] <= wr1_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/trace_commit_arbiter.sv
// Captures retiring register writes from two commit slots into an ordered trace FIFO,
// drops and counts records on overflow, and drains to DONE once the end PC retires.
module trace_commit_arbiter
  import trace_commit_arbiter_pkg::*;
#(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] END_PC = 32'hbfc00100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trace_en,
  input  debug_bus_t debug_bus1,
  input  debug_bus_t debug_bus2,
  output logic       stall,
  output logic       rec_valid,
  input  logic       rec_ready,
  output trace_rec_t rec,
  output logic [7:0] overflow_cnt,
  output logic       done
);

  localparam int CW = $clog2(DEPTH) + 1;

  trace_arb_state_e state_q, state_d;
  logic [31:0]      seq_q, seq_d;
  logic [7:0]       ovf_q, ovf_d;
  logic [CW-1:0]    count, free;
  logic             run, end1, end2, q1, q2, wr0_en, wr1_en, pop;
  logic [1:0]       n_qual, n_enq, n_drop;
  logic [8:0]       ovf_sum;
  trace_rec_t       rec1, rec2, wr0_data;

  assign rec_valid = (count != '0);
  assign pop       = rec_valid && rec_ready;

  always_comb begin
    run  = (state_q == ST_RUN);
    end1 = debug_bus1.valid && (debug_bus1.pc == END_PC);
    end2 = debug_bus2.valid && (debug_bus2.pc == END_PC);
    q1   = run && trace_en && debug_bus1.valid && (debug_bus1.wstrb != 4'h0) && (debug_bus1.dest != 5'd0);
    // Slot 2 is younger than an end-PC slot 1, so it lies past the end of the test.
    q2   = run && trace_en && debug_bus2.valid && (debug_bus2.wstrb != 4'h0) && (debug_bus2.dest != 5'd0) && !end1;

    free  = CW'(DEPTH) - count;
    stall = run && (free < CW'(2));

    wr0_en = (q1 || q2) && (free != '0);
    wr1_en = q1 && q2 && (free >= CW'(2));

    rec1 = '{seq: seq_q, pc: debug_bus1.pc, dest: debug_bus1.dest,
             wdata: mask_wdata(debug_bus1.wdata, debug_bus1.wstrb)};
    rec2 = '{seq: seq_q + 32'(q1), pc: debug_bus2.pc, dest: debug_bus2.dest,
             wdata: mask_wdata(debug_bus2.wdata, debug_bus2.wstrb)};
    wr0_data = q1 ? rec1 : rec2;

    n_qual = {1'b0, q1} + {1'b0, q2};
    n_enq  = {1'b0, wr0_en} + {1'b0, wr1_en};
    n_drop = n_qual - n_enq;
    seq_d  = seq_q + 32'(n_enq);

    ovf_sum = {1'b0, ovf_q} + 9'(n_drop);
    ovf_d   = ovf_sum[8] ? 8'hff : ovf_sum[7:0];

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (end1 || end2) state_d = ST_DRAIN;
      ST_DRAIN: if ((count == '0) || ((count == CW'(1)) && pop)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state math lives in always_comb.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      seq_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr0_en   (wr0_en),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_data (rec2),
    .rd_en    (pop),
    .rd_data  (rec),
    .count    (count)
  );

  assign overflow_cnt = ovf_q;
  assign done         = (state_q == ST_DONE);

endmodule
